// File: rtl/portao_pkg.sv
// Shared types and glyphs for the automatic gate controller.
// State/direction encodings and active-low gfedcba segment patterns.
package portao_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOPPED = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    typedef enum logic {
        DIR_OPEN  = 1'b0,
        DIR_CLOSE = 1'b1
    } dir_e;

    localparam logic [6:0] HEX_CLOSED  = 7'b0001110;
    localparam logic [6:0] HEX_OPEN    = 7'b0001000;
    localparam logic [6:0] HEX_MOVING  = 7'b0111111;
    localparam logic [6:0] HEX_STOPPED = 7'b0001100;
    localparam logic [6:0] HEX_FAULT   = 7'b0000110;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [6:0] state_glyph(input state_e s);
        logic [6:0] g;
        case (s)
            ST_CLOSED:              g = HEX_CLOSED;
            ST_OPEN:                g = HEX_OPEN;
            ST_OPENING, ST_CLOSING: g = HEX_MOVING;
            ST_STOPPED:             g = HEX_STOPPED;
            default:                g = HEX_FAULT;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/portao_debounce.sv
// Push-button front end: 2-FF synchroniser, stable-count debouncer and
// registered falling-edge press pulse.
module portao_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW =
        $clog2(DEBOUNCE_CYC > 1 ? DEBOUNCE_CYC : 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic          deb_dly_q, deb_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synced level disagrees with the
    // accepted level; any agreement restarts the count.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        deb_dly_d = deb_q;
        press_d   = deb_dly_q & ~deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/portao_auto.sv
// Automatic gate controller: limits, obstacle reversal, travel watchdog.
// Timed auto-close in OPEN is enabled by defining PORTAO_AUTOCLOSE_EN.
module portao_auto
    import portao_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 27_000_000,
    parameter int unsigned DEBOUNCE_CYC   = 270_000,
    parameter int unsigned TRAVEL_MAX_CYC = 270_000_000,
    parameter int unsigned HOLD_OPEN_CYC  = 135_000_000
) (
    input  logic       CLOCK_27,
    input  logic       RESET,
    input  logic       KEY_N,
    input  logic       LIMIT_OPEN,
    input  logic       LIMIT_CLOSED,
    input  logic       OBSTACLE,
    output logic       MOTOR_OPEN,
    output logic       MOTOR_CLOSE,
    output logic [6:0] HEX0,
    output logic       LEDG,
    output logic       LEDR,
    output logic       FAULT
);

`ifdef PORTAO_AUTOCLOSE_EN
    localparam bit AUTOCLOSE = 1'b1;
`else
    localparam bit AUTOCLOSE = 1'b0;
`endif

    localparam int unsigned TW =
        $clog2(max3(DEBOUNCE_CYC, TRAVEL_MAX_CYC, HOLD_OPEN_CYC));
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_MAX_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_OPEN_CYC - 1);

    // Clock rate is descriptive only.
    logic unused_clk_hz;
    assign unused_clk_hz = ^CLK_HZ;

    logic [2:0]    sync1_q, sync2_q;
    logic          lo_s, lc_s, ob_s;
    logic          press;
    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [TW-1:0] tmr_q, tmr_d;

    portao_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (CLOCK_27),
        .rst  (RESET),
        .key_n(KEY_N),
        .press(press)
    );

    assign lo_s = sync2_q[2];
    assign lc_s = sync2_q[1];
    assign ob_s = sync2_q[0];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (lo_s && lc_s) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_CLOSED: begin
                    if (press) state_d = ST_OPENING;
                end
                ST_OPENING: begin
                    if (lo_s) begin
                        state_d = ST_OPEN;
                    end else if (press) begin
                        state_d = ST_STOPPED;
                        dir_d   = DIR_OPEN;
                    end else if (tmr_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_OPEN: begin
                    if (press) begin
                        state_d = ST_CLOSING;
                    end else if (AUTOCLOSE && !ob_s
                                 && tmr_q == HOLD_LAST) begin
                        state_d = ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (ob_s) begin
                        state_d = ST_OPENING;
                    end else if (lc_s) begin
                        state_d = ST_CLOSED;
                    end else if (press) begin
                        state_d = ST_STOPPED;
                        dir_d   = DIR_CLOSE;
                    end else if (tmr_q == TRAVEL_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_STOPPED: begin
                    if (lc_s) begin
                        state_d = ST_CLOSED;
                    end else if (lo_s) begin
                        state_d = ST_OPEN;
                    end else if (press) begin
                        if (dir_q == DIR_CLOSE) begin
                            state_d = ST_OPENING;
                        end else if (!ob_s) begin
                            state_d = ST_CLOSING;
                        end
                    end
                end
                default: state_d = ST_FAULT;
            endcase
        end

        // Shared timer: restarts on every transition, saturates otherwise.
        tmr_d = tmr_q;
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (AUTOCLOSE && state_q == ST_OPEN && ob_s) begin
            tmr_d = '0;
        end else if (tmr_q != '1) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_27) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= ST_STOPPED;
            dir_q   <= DIR_OPEN;
            tmr_q   <= '0;
        end else begin
            sync1_q <= {LIMIT_OPEN, LIMIT_CLOSED, OBSTACLE};
            sync2_q <= sync1_q;
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
        end
    end

    assign MOTOR_OPEN  = (state_q == ST_OPENING);
    assign MOTOR_CLOSE = (state_q == ST_CLOSING);
    assign LEDG        = MOTOR_OPEN;
    assign LEDR        = MOTOR_CLOSE;
    assign FAULT       = (state_q == ST_FAULT);
    assign HEX0        = state_glyph(state_q);

endmodule
